auth_cmd_fsm: RTL
=================

// Module: auth_cmd_fsm
// PURPOSE
// Parametrised rider-authorisation controller between the BLE UART receiver and the balance/steer
// core. Consumes command bytes (GO/STOP), tracks rider presence and drives pwr_up. Adds a
// heartbeat timeout that forces a STOP if GO is not refreshed, plus an error pulse for bad bytes.
// PARAMETERS
// DATA_W      8      command byte width
// GO_CODE     8'h67  power-up / heartbeat-refresh command
// STOP_CODE   8'h73  power-down request
// KEY_CODE    8'h6B  unlock byte (used only with AUTH_KEY_EN)
// HB_TIMEOUT  0      clk cycles in PWR1 without GO before forced STOP; 0 = heartbeat disabled
// PORTS
// clk         in   1       system clock, all flops rising edge
// rst         in   1       asynchronous, active-high reset
// rx_rdy      in   1       UART byte valid (level, held until clr_rx_rdy)
// rx_data     in   DATA_W  received byte, stable while rx_rdy=1
// rider_off   in   1       load cells report no rider
// clr_rx_rdy  out  1       one-cycle pulse acknowledging consumed byte
// pwr_up      out  1       enable to balance control / motor drive
// hb_tmo      out  1       one-cycle pulse on heartbeat expiry
// cmd_err     out  1       one-cycle pulse on unrecognised or refused byte
// state       out  2       OFF=0, PWR1=1, PWR2=2 (debug)
// BEHAVIOUR
// - Reset: state=OFF, pwr_up=0, clr_rx_rdy=0, hb_tmo=0, cmd_err=0, hb counter=0, key_armed=0.
// - Consume: byte taken at edge where rx_rdy=1 and clr_rx_rdy=0; clr_rx_rdy=1 next cycle; rx_rdy
//   ignored while clr_rx_rdy=1. Max one byte per 2 cycles. State updates at consume edge.
// - pwr_up = (state!=OFF), decoded from state flops only; no comb path from inputs.
//   Latency rx_rdy high -> pwr_up change: 1 clk.
// - FSM: OFF  : GO -> PWR1; STOP/other -> OFF.
//        PWR1 : STOP & rider_off -> OFF; STOP & !rider_off -> PWR2; GO -> PWR1 (hb refresh).
//        PWR2 : GO -> PWR1; rider_off=1 (any cycle, no byte needed) -> OFF.
//   rider_off sampled same edge as byte; in PWR1 it alone causes no transition.
// - Heartbeat (HB_TIMEOUT>0): counter width $clog2(HB_TIMEOUT+1); counts only in PWR1; cleared on
//   PWR1 entry and on each GO in PWR1; at count==HB_TIMEOUT-1 -> hb_tmo pulse, treated as STOP
//   (rider_off ? OFF : PWR2), counter cleared. Never wraps. HB_TIMEOUT=0: counter tied 0, hb_tmo=0.
// - Simultaneous: GO consumed on expiry edge -> GO wins, no hb_tmo, stay PWR1. STOP on expiry
//   edge -> one STOP transition, no hb_tmo. PWR2 with GO and rider_off same edge -> OFF.
// - cmd_err: pulses with clr_rx_rdy when byte is not GO/STOP (/KEY when enabled), or refused GO.
// - Reset mid-operation: all state and pending ack cleared immediately; byte left in UART is
//   re-consumed after release (receiver owns rx_rdy).
// CONFIGURATION
// AUTH_KEY_EN defined: key_armed flop set by consumed KEY_CODE, cleared by any other consumed
//   byte and by entry to OFF. GO from OFF or PWR2 honoured only if key_armed, else refused:
//   state unchanged, cmd_err pulse. GO in PWR1 (refresh) needs no key. KEY_CODE is not cmd_err.
// AUTH_KEY_EN undefined: no key_armed flop; KEY_CODE is an ordinary unrecognised byte (cmd_err);
//   GO always honoured per FSM.
// TESTING (bench: GO=8'h67, STOP=8'h73, KEY=8'h6B, HB_TIMEOUT=1000)
// 1 rst pulse; send 8'h67, rider_off=0 -> clr_rx_rdy 1 clk later, pwr_up=1, state=1 after 1 clk.
// 2 PWR1, send 8'h73 rider_off=0 -> state=2 pwr_up=1; raise rider_off -> state=0 pwr_up=0 next clk.
// 3 OFF: send 8'h73 then 8'h66 -> pwr_up stays 0; cmd_err pulses once for 8'h66 only.
// 4 PWR1, no bytes 1000 clks, rider_off=0 -> hb_tmo pulse at clk 1000, state=2; repeat with
//   GO every 900 clks -> no hb_tmo over 5000 clks; GO on expiry edge -> no hb_tmo, state=1.
// 5 AUTH_KEY_EN: OFF, send 8'h67 -> cmd_err, pwr_up=0; send 8'h6B,8'h67 -> pwr_up=1;
//   send 8'h6B,8'h66,8'h67 -> refused (key disarmed by 8'h66).
// 6 Assert rst while PWR1 and clr_rx_rdy=1 -> all outputs 0 same cycle; release -> OFF.

Source files
------------

// File: rtl/auth_cmd_fsm.sv
// Rider-authorisation controller: consumes GO/STOP command bytes, tracks rider presence, drives pwr_up.
// Optional key-unlock gate on GO is enabled by defining AUTH_KEY_EN.
module auth_cmd_fsm #(
  parameter int                DATA_W     = 8,
  parameter logic [DATA_W-1:0] GO_CODE    = 8'h67,
  parameter logic [DATA_W-1:0] STOP_CODE  = 8'h73,
  parameter logic [DATA_W-1:0] KEY_CODE   = 8'h6B,
  parameter int                HB_TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_rdy,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rider_off,
  output logic              clr_rx_rdy,
  output logic              pwr_up,
  output logic              hb_tmo,
  output logic              cmd_err,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_PWR1 = 2'd1,
    S_PWR2 = 2'd2
  } state_t;

  localparam bit HB_EN = (HB_TIMEOUT > 0);
  localparam int CNT_W = HB_EN ? $clog2(HB_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] HB_LAST = HB_EN ? CNT_W'(HB_TIMEOUT - 1) : '0;

`ifdef AUTH_KEY_EN
  localparam bit KEY_ACCEPT = 1'b1;
`else
  localparam bit KEY_ACCEPT = 1'b0;
`endif

  state_t           r_state;
  logic [CNT_W-1:0] r_hb_cnt;
  logic             r_clr;
  logic             r_tmo;
  logic             r_err;

  logic w_take;
  logic w_go;
  logic w_stop;
  logic w_key_byte;
  logic w_bad;
  logic w_expire;
  logic w_key_ok;
  logic w_go_ok;
  logic w_enter_off;

  // A byte is only taken while no acknowledge is outstanding, so each byte is consumed once.
  assign w_take     = rx_rdy & ~r_clr;
  assign w_go       = w_take & (rx_data == GO_CODE);
  assign w_stop     = w_take & (rx_data == STOP_CODE);
  assign w_key_byte = (rx_data == KEY_CODE);
  assign w_bad      = w_take & ~w_go & ~w_stop & ~(KEY_ACCEPT & w_key_byte);
  assign w_expire   = HB_EN && (r_state == S_PWR1) && (r_hb_cnt == HB_LAST);
  assign w_go_ok    = w_go & w_key_ok;

  assign w_enter_off = ((r_state == S_PWR1) && !w_go && (w_stop || w_expire) && rider_off) ||
                       ((r_state == S_PWR2) && rider_off);

`ifdef AUTH_KEY_EN
  logic r_key_armed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_key_armed <= 1'b0;
    end else if (w_enter_off) begin
      r_key_armed <= 1'b0;
    end else if (w_take) begin
      r_key_armed <= w_key_byte;
    end
  end

  assign w_key_ok = r_key_armed;
`else
  assign w_key_ok = 1'b1;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_OFF;
      r_hb_cnt <= '0;
      r_clr    <= 1'b0;
      r_tmo    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_clr <= w_take;
      r_tmo <= 1'b0;
      r_err <= w_bad;
      unique case (r_state)
        S_OFF: begin
          if (w_go_ok) begin
            r_state  <= S_PWR1;
            r_hb_cnt <= '0;
          end else if (w_go) begin
            r_err <= 1'b1;
          end
        end
        S_PWR1: begin
          if (w_go) begin
            r_hb_cnt <= '0;
          end else if (w_stop || w_expire) begin
            // An expiry is an implicit STOP; a real STOP on the same edge suppresses the pulse.
            r_state  <= rider_off ? S_OFF : S_PWR2;
            r_hb_cnt <= '0;
            r_tmo    <= w_expire & ~w_stop;
          end else if (HB_EN) begin
            r_hb_cnt <= r_hb_cnt + CNT_W'(1);
          end
        end
        S_PWR2: begin
          if (rider_off) begin
            r_state <= S_OFF;
          end else if (w_go_ok) begin
            r_state  <= S_PWR1;
            r_hb_cnt <= '0;
          end else if (w_go) begin
            r_err <= 1'b1;
          end
        end
        default: begin
          r_state  <= S_OFF;
          r_hb_cnt <= '0;
        end
      endcase
    end
  end

  assign clr_rx_rdy = r_clr;
  assign hb_tmo     = r_tmo;
  assign cmd_err    = r_err;
  assign state      = r_state;
  assign pwr_up     = (r_state != S_OFF);

endmodule
